// File: rtl/game_tick_scheduler.sv
// Game-flow controller: IDLE/READY/PLAY/DEAD sequencing plus scroll and gravity tick prescalers.
// Define TICK_SPEEDUP_EN to shorten the scroll period as pipes are passed (speed levels 0..7).
module game_tick_scheduler #(
    parameter int WIDTH         = 24,
    parameter int SCROLL_PERIOD = 1000000,
    parameter int GRAV_PERIOD   = 750000,
    parameter int READY_CYCLES  = 50000000,
    parameter int SCROLL_MIN    = 250000,
    parameter int PERIOD_STEP   = 125000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startGame,
    input  logic       flap,
    input  logic       collide,
    input  logic       pipe_passed,
    output logic       scroll_tick,
    output logic       gravity_tick,
    output logic [1:0] state,
    output logic [2:0] level
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_READY = 2'b01,
        S_PLAY  = 2'b10,
        S_DEAD  = 2'b11
    } state_t;

    // The get-ready hold is sized on its own; it may exceed the prescaler width.
    localparam int RDY_W = (READY_CYCLES > 1) ? $clog2(READY_CYCLES) : 1;
    localparam logic [RDY_W-1:0] RDY_LAST    = RDY_W'(READY_CYCLES - 1);
    localparam logic [WIDTH-1:0] SCROLL_INIT = WIDTH'(SCROLL_PERIOD);
    localparam logic [WIDTH-1:0] GRAV_LAST   = WIDTH'(GRAV_PERIOD - 1);

    state_t           state_q;
    state_t           state_d;
    logic             enter_ready;
    logic             play_run;
    logic             scroll_wrap;
    logic             grav_wrap;
    logic [RDY_W-1:0] rdy_cnt;
    logic [WIDTH-1:0] scroll_cnt;
    logic [WIDTH-1:0] grav_cnt;
    logic [WIDTH-1:0] scroll_period;
    logic [WIDTH-1:0] scroll_last;
    logic [2:0]       level_q;

    always_comb begin
        state_d     = state_q;
        enter_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (startGame) begin
                    state_d     = S_READY;
                    enter_ready = 1'b1;
                end
            end
            S_READY: begin
                if (!startGame)
                    state_d = S_IDLE;
                else if (rdy_cnt == RDY_LAST)
                    state_d = S_PLAY;
            end
            S_PLAY: begin
                if (collide || !startGame)
                    state_d = S_DEAD;
            end
            S_DEAD: begin
                if (!startGame)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // A cycle that is leaving PLAY (collide or start released) neither counts nor ticks.
    assign play_run    = (state_q == S_PLAY) && !collide && startGame;
    assign scroll_last = scroll_period - WIDTH'(1);
    assign scroll_wrap = play_run && (scroll_cnt == scroll_last);
    assign grav_wrap   = play_run && !flap && (grav_cnt == GRAV_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rdy_cnt <= '0;
        else if (enter_ready)
            rdy_cnt <= '0;
        else if ((state_q == S_READY) && (rdy_cnt != RDY_LAST))
            rdy_cnt <= rdy_cnt + RDY_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scroll_cnt <= '0;
            grav_cnt   <= '0;
        end else if (enter_ready) begin
            scroll_cnt <= '0;
            grav_cnt   <= '0;
        end else if (play_run) begin
            scroll_cnt <= scroll_wrap ? '0 : scroll_cnt + WIDTH'(1);
            if (flap || (grav_cnt == GRAV_LAST))
                grav_cnt <= '0;
            else
                grav_cnt <= grav_cnt + WIDTH'(1);
        end
    end

    // Tick stage: terminal counts register into single-cycle enables.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scroll_tick  <= 1'b0;
            gravity_tick <= 1'b0;
        end else begin
            scroll_tick  <= scroll_wrap;
            gravity_tick <= grav_wrap;
        end
    end

`ifdef TICK_SPEEDUP_EN
    localparam logic signed [WIDTH+4:0] SP_S   = (WIDTH+5)'(SCROLL_PERIOD);
    localparam logic signed [WIDTH+4:0] STEP_S = (WIDTH+5)'(PERIOD_STEP);
    localparam logic signed [WIDTH+4:0] MIN_S  = (WIDTH+5)'(SCROLL_MIN);
    localparam logic [WIDTH-1:0]        MIN_U  = WIDTH'(SCROLL_MIN);

    logic [1:0] pass_cnt;

    function automatic logic [2:0] level_sat_inc(input logic [2:0] l);
        return (l == 3'd7) ? l : l + 3'd1;
    endfunction

    // Period shrinks by one step per level, clamped at the floor; signed so the difference may go negative.
    function automatic logic [WIDTH-1:0] period_for_level(input logic [2:0] l);
        logic signed [WIDTH+4:0] lv;
        logic signed [WIDTH+4:0] p;
        lv = $signed({{(WIDTH+2){1'b0}}, l});
        p  = SP_S - lv * STEP_S;
        if (p < MIN_S)
            return MIN_U;
        return p[WIDTH-1:0];
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pass_cnt      <= 2'd0;
            level_q       <= 3'd0;
            scroll_period <= SCROLL_INIT;
        end else if (enter_ready) begin
            pass_cnt      <= 2'd0;
            level_q       <= 3'd0;
            scroll_period <= SCROLL_INIT;
        end else begin
            if (play_run && pipe_passed) begin
                pass_cnt <= pass_cnt + 2'd1;
                if (pass_cnt == 2'd3)
                    level_q <= level_sat_inc(level_q);
            end
            // New period is picked up only at a wrap so a running interval is never cut short.
            if (scroll_wrap)
                scroll_period <= period_for_level(level_q);
        end
    end
`else
    logic unused_pipe_passed;

    assign unused_pipe_passed = pipe_passed;
    assign level_q            = 3'd0;
    assign scroll_period      = SCROLL_INIT;
`endif

    assign state = state_q;
    assign level = level_q;

endmodule
